float_divider: RTL and testbench

//  Sequential IEEE-754-style float divider, the inverse of float_multiplier: out_quot = in_a / in_b.

---
 rtl/float_divider.sv | 198 +++++++++++++++++++
 tb/tb_float_divider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/float_divider.sv
`default_nettype none
// ============================================================================
// Module      : float_divider
// Description : Sequential IEEE-754-style floating-point divider,
//               out_quot = in_a / in_b. Fields are packed as
//               sign | exponent | mantissa with a hidden leading 1.
//               The mantissas are divided by restoring division, one
//               quotient bit per clock. Zero and inf/NaN operands bypass
//               the divider and finish right after UNPACK. Subnormal
//               inputs are flushed to zero and no subnormal is produced.
//               Build option FLOAT_DIVIDER_ROUND_EN selects
//               round-to-nearest-even. Without it the result is
//               truncated (round toward zero). Latency is the same in
//               both builds.
// Ports       : in_clk       clock, rising edge
//               in_rst       synchronous active-low reset
//               in_a         dividend, sampled on the start edge
//               in_b         divisor, sampled on the start edge
//               in_start     start request, honoured in IDLE/DONE only
//               out_finished high while DONE, out_quot valid
//               out_quot     registered quotient
// Revision    : 1.0 - initial release
// ============================================================================
module float_divider #(
    parameter int BITS     = 16,
    parameter int EXP_BITS = 5
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    input  logic            in_start,
    output logic            out_finished,
    output logic [BITS-1:0] out_quot
);

    localparam int c_mant_bits = BITS - EXP_BITS - 1;
    localparam int c_bias      = 2**(EXP_BITS-1) - 1;
    localparam int c_qw        = c_mant_bits + 3;     // integer + fraction + guard + round
    localparam int c_rw        = c_mant_bits + 2;     // remainder stays below 2*mb
    localparam int c_ew        = EXP_BITS + 2;        // signed working exponent
    localparam int c_cnt_w     = $clog2(c_qw + 1);

    localparam logic [c_ew-1:0]    c_bias_e   = c_ew'(c_bias);
    localparam logic [c_ew-1:0]    c_exp_max  = c_ew'(2**EXP_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_qw - 1);
    localparam logic [BITS-1:0]    c_qnan     =
        {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(c_mant_bits-1){1'b0}}};

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_unpack    = 3'd1;
    localparam logic [2:0] c_divide    = 3'd2;
    localparam logic [2:0] c_normalise = 3'd3;
    localparam logic [2:0] c_done      = 3'd4;

    logic [2:0]             r_state;
    logic [BITS-1:0]        r_a;
    logic [BITS-1:0]        r_b;
    logic                   r_sign;
    logic [c_ew-1:0]        r_exp;
    logic [c_mant_bits:0]   r_mb;
    logic [c_rw-1:0]        r_rem;
    logic [c_qw-1:0]        r_q;
    logic [c_cnt_w-1:0]     r_cnt;

    // ---------------- operand decode (used in UNPACK) ----------------
    logic [EXP_BITS-1:0] w_ea, w_eb;
    logic                w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic                w_sign;
    logic [c_ew-1:0]     w_exp_unb;

    assign w_ea      = r_a[BITS-2 -: EXP_BITS];
    assign w_eb      = r_b[BITS-2 -: EXP_BITS];
    assign w_a_zero  = (w_ea == '0);
    assign w_b_zero  = (w_eb == '0);
    assign w_a_nan   = (&w_ea) & (|r_a[c_mant_bits-1:0]);
    assign w_b_nan   = (&w_eb) & (|r_b[c_mant_bits-1:0]);
    assign w_a_inf   = (&w_ea) & ~(|r_a[c_mant_bits-1:0]);
    assign w_b_inf   = (&w_eb) & ~(|r_b[c_mant_bits-1:0]);
    assign w_sign    = r_a[BITS-1] ^ r_b[BITS-1];
    // Two's-complement wrap in c_ew bits gives the signed difference.
    assign w_exp_unb = {2'b00, w_ea} - {2'b00, w_eb} + c_bias_e;

    // ---------------- restoring division step ----------------
    logic            w_ge;
    logic [c_rw-1:0] w_rem_next;

    assign w_ge       = (r_rem >= {1'b0, r_mb});
    assign w_rem_next = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

    // ---------------- normalise and round ----------------
    // The quotient lies in (0.5, 2): when the integer bit is clear, one
    // left shift brings the leading 1 into place.
    logic                   w_msb;
    logic [c_mant_bits-1:0] w_frac_n;
    logic [c_ew-1:0]        w_exp_n;
    logic                   w_inc;
    logic [c_mant_bits:0]   w_frac_rnd;
    logic [c_ew-1:0]        w_exp_f;
    logic [BITS-1:0]        w_result;

    assign w_msb    = r_q[c_qw-1];
    assign w_frac_n = w_msb ? r_q[c_qw-2:2] : r_q[c_qw-3:1];
    assign w_exp_n  = w_msb ? r_exp : (r_exp - 1'b1);

`ifdef FLOAT_DIVIDER_ROUND_EN
    logic w_guard, w_round, w_sticky;
    assign w_guard  = w_msb ? r_q[1] : r_q[0];
    assign w_round  = w_msb ? r_q[0] : 1'b0;
    assign w_sticky = |r_rem;
    assign w_inc    = w_guard & (w_round | w_sticky | w_frac_n[0]);
`else
    logic w_unused_round_bit;
    assign w_unused_round_bit = r_q[0];
    assign w_inc              = 1'b0;
`endif

    assign w_frac_rnd = {1'b0, w_frac_n} + {{c_mant_bits{1'b0}}, w_inc};
    // A carry out leaves the fraction at zero and bumps the exponent.
    assign w_exp_f    = w_exp_n + {{(c_ew-1){1'b0}}, w_frac_rnd[c_mant_bits]};

    always_comb begin
        w_result = {r_sign, w_exp_f[EXP_BITS-1:0], w_frac_rnd[c_mant_bits-1:0]};
        if ($signed(w_exp_f) >= $signed(c_exp_max))
            w_result = {r_sign, {EXP_BITS{1'b1}}, {c_mant_bits{1'b0}}};
        else if ($signed(w_exp_f) <= $signed({c_ew{1'b0}}))
            w_result = {r_sign, {(BITS-1){1'b0}}};
    end

    // ---------------- control ----------------
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            r_state      <= c_idle;
            r_a          <= '0;
            r_b          <= '0;
            r_sign       <= 1'b0;
            r_exp        <= '0;
            r_mb         <= '0;
            r_rem        <= '0;
            r_q          <= '0;
            r_cnt        <= '0;
            out_finished <= 1'b0;
            out_quot     <= '0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (in_start) begin
                        r_a          <= in_a;
                        r_b          <= in_b;
                        out_finished <= 1'b0;
                        r_state      <= c_unpack;
                    end
                end
                c_unpack: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp_unb;
                    r_mb   <= {1'b1, r_b[c_mant_bits-1:0]};
                    r_rem  <= {1'b0, 1'b1, r_a[c_mant_bits-1:0]};
                    r_q    <= '0;
                    r_cnt  <= '0;
                    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
                        out_quot     <= c_qnan;
                        out_finished <= 1'b1;
                        r_state      <= c_done;
                    end else if (w_b_zero || w_a_inf) begin
                        out_quot     <= {w_sign, {EXP_BITS{1'b1}}, {c_mant_bits{1'b0}}};
                        out_finished <= 1'b1;
                        r_state      <= c_done;
                    end else if (w_a_zero || w_b_inf) begin
                        out_quot     <= {w_sign, {(BITS-1){1'b0}}};
                        out_finished <= 1'b1;
                        r_state      <= c_done;
                    end else begin
                        r_state <= c_divide;
                    end
                end
                c_divide: begin
                    r_q   <= {r_q[c_qw-2:0], w_ge};
                    r_rem <= w_rem_next << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last)
                        r_state <= c_normalise;
                end
                c_normalise: begin
                    out_quot     <= w_result;
                    out_finished <= 1'b1;
                    r_state      <= c_done;
                end
                default: begin
                    r_state      <= c_idle;
                    out_finished <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_float_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_divider
// Description : Self-checking bench for float_divider (16-bit, 5-bit exp).
//               Vector table of {a, b, quotient, latency}, scoreboard queue
//               of expected results, plus reset and start-ignore sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_divider;

    localparam int c_lat_norm = 16;
    localparam int c_lat_spec = 2;
    localparam int c_max_wait = 40;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_start;
    logic        out_finished;
    logic [15:0] out_quot;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t        vecs[$];
    logic [15:0] sb_q[$];
    int          sb_lat[$];

    float_divider #(.BITS(16), .EXP_BITS(5)) dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_start     (in_start),
        .out_finished (out_finished),
        .out_quot     (out_quot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic add(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input int lat);
        vec_t v;
        v.name = nm; v.a = a; v.b = b; v.q = q; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Runs one division. toggle_at > 0 pulses in_start with other operands
    // after that many edges, which the divider must ignore.
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] q, input int lat, input int toggle_at);
        logic [15:0] eq;
        int          el;
        int          n;
        sb_q.push_back(q);
        sb_lat.push_back(lat);
        @(negedge clk);
        in_a = a; in_b = b; in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        n = 1;
        while (!out_finished && n < c_max_wait) begin
            if (n == toggle_at) begin
                in_start = 1'b1; in_a = 16'h3c00; in_b = 16'h4000;
            end else begin
                in_start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        in_start = 1'b0;
        eq = sb_q.pop_front();
        el = sb_lat.pop_front();
        if (!out_finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: out_finished=0 after %0d edges, required 1", nm, n);
        end else begin
            check({nm, "_latency"}, 32'(n), 32'(el));
            check({nm, "_quot"}, {16'h0, out_quot}, {16'h0, eq});
        end
    endtask

    initial begin
        rst = 1'b0; in_a = '0; in_b = '0; in_start = 1'b0;

        add("div_neg",    16'he640, 16'hcc00, 16'h5640, c_lat_norm);
        add("div_half",   16'hb000, 16'hb400, 16'h3800, c_lat_norm);
`ifdef FLOAT_DIVIDER_ROUND_EN
        add("div_10_3",   16'h4900, 16'h4200, 16'h42ab, c_lat_norm);
`else
        add("div_10_3",   16'h4900, 16'h4200, 16'h42aa, c_lat_norm);
`endif
        add("div_1_3",    16'h3c00, 16'h4200, 16'h3555, c_lat_norm);
        add("div_6_2",    16'h4600, 16'h4000, 16'h4200, c_lat_norm);
        add("div_1_m1",   16'h3c00, 16'hbc00, 16'hbc00, c_lat_norm);
        add("ovf",        16'h7bff, 16'h0400, 16'h7c00, c_lat_norm);
        add("unf",        16'h0400, 16'h7bff, 16'h0000, c_lat_norm);
        add("x_by_0",     16'hbc00, 16'h0000, 16'hfc00, c_lat_spec);
        add("zero_zero",  16'h0000, 16'h0000, 16'h7e00, c_lat_spec);
        add("zero_by_x",  16'h0000, 16'h4200, 16'h0000, c_lat_spec);
        add("inf_by_x",   16'h7c00, 16'h4000, 16'h7c00, c_lat_spec);
        add("x_by_inf",   16'hc000, 16'h7c00, 16'h8000, c_lat_spec);
        add("nan_op",     16'h7c01, 16'h3c00, 16'h7e00, c_lat_spec);
        add("inf_inf",    16'hfc00, 16'h7c00, 16'h7e00, c_lat_spec);

        repeat (3) @(posedge clk);
        #1;
        check("reset_finished", {31'h0, out_finished}, 32'h0);
        check("reset_quot", {16'h0, out_quot}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table sweep; consecutive entries start straight from DONE.
        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lat, 0);

        // Start request pulsed mid-DIVIDE must not disturb the result.
        run_op("start_ignored", 16'h4900, 16'h4200, vecs[2].q, c_lat_norm, 6);

        // Back-to-back from DONE.
        run_op("b2b_first",  16'h4600, 16'h4000, 16'h4200, c_lat_norm, 0);
        run_op("b2b_second", 16'he640, 16'hcc00, 16'h5640, c_lat_norm, 0);

        // Reset in DIVIDE cycle 5 (edge 7 counting the start edge).
        @(negedge clk);
        in_a = 16'h4600; in_b = 16'h4000; in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_quot_divide", {16'h0, out_quot}, 32'h5640);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_finished", {31'h0, out_finished}, 32'h0);
        check("midrst_quot", {16'h0, out_quot}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (out_finished) seen++;
            end
            check("idle_after_rst", 32'(seen), 32'h0);
        end

        run_op("after_rst", 16'h3c00, 16'h4200, 16'h3555, c_lat_norm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
